// File: rtl/step_gen_pkg.sv
// Shared encodings for the step-pulse generator: rate modes, FSM states, rate constants.
package step_gen_pkg;

  typedef enum logic [1:0] {
    MODE_32    = 2'b00,
    MODE_64    = 2'b01,
    MODE_128   = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } state_e;

  localparam int RATE_32  = 32;
  localparam int RATE_64  = 64;
  localparam int RATE_128 = 128;

endpackage

// File: rtl/pulse_bounce_shaper.sv
// Registers the pulse level for the upcoming cycle, with optional contact chatter at the rising edge.
// Latency: 1 edge from the next-state inputs; no backpressure.
module pulse_bounce_shaper
  import step_gen_pkg::*;
#(
  parameter int PCW        = 28,
  parameter int HIGH_CYC   = 1000,
  parameter int BOUNCE_CYC = 8
) (
  input  logic           clk100Mhz,
  input  logic           rst_n,
  input  state_e         state_nx,
  input  logic [PCW-1:0] pc,
  input  logic           bounce_en,
  output logic           pulse
);

  localparam logic [PCW-1:0] HIGH_LIM = PCW'(HIGH_CYC);
  localparam logic [PCW-1:0] BNC_LIM  = PCW'(BOUNCE_CYC);

  logic chatter;
  logic level;

  // Chatter drops the line on odd counts inside the bounce window.
  always_comb begin
    chatter = bounce_en && (pc < BNC_LIM) && pc[0];
    level   = (state_nx == ST_HIGH) && (pc < HIGH_LIM) && !chatter;
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
    end else begin
      pulse <= level;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Programmable step-pulse source (32/64/128 per second or bursts) with optional bounce emulation.
// Latency: pulse rises 1 edge after i_enable is sampled; free-running source, no backpressure.
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int HIGH_CYC   = 1000,
  parameter int BOUNCE_CYC = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic        clk100Mhz,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic        i_bounce_en,
  input  logic        i_clr,
  output logic        o_pulse,
  output logic [15:0] o_pulse_cnt,
  output logic        o_busy
);

  localparam int PCW = $clog2(CLK_HZ) + 1;
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PCW-1:0] LAST_32    = PCW'(CLK_HZ / RATE_32 - 1);
  localparam logic [PCW-1:0] LAST_64    = PCW'(CLK_HZ / RATE_64 - 1);
  localparam logic [PCW-1:0] LAST_128   = PCW'(CLK_HZ / RATE_128 - 1);
  localparam logic [PCW-1:0] HIGH_LAST  = PCW'(HIGH_CYC - 1);
  localparam logic [PCW-1:0] GAP_LAST   = PCW'(CLK_HZ - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

  state_e         state, state_nx;
  logic [PCW-1:0] pc, pc_nx;
  logic [PCW-1:0] gap_cnt, gap_nx;
  logic [PCW-1:0] per_last;
  mode_e          mode_q, mode_nx;
  logic           bounce_q, bounce_nx;
  logic [BCW-1:0] burst_cnt, burst_nx;
  logic           start;
  logic [15:0]    cnt_nx;

  // Burst pulses reuse the fastest period.
  always_comb begin
    per_last = LAST_128;
    case (mode_q)
      MODE_32: per_last = LAST_32;
      MODE_64: per_last = LAST_64;
      default: per_last = LAST_128;
    endcase
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    gap_nx    = gap_cnt;
    mode_nx   = mode_q;
    bounce_nx = bounce_q;
    burst_nx  = burst_cnt;
    start     = 1'b0;

    case (state)
      ST_IDLE: start = i_enable;
      ST_HIGH: begin
        pc_nx = pc + 1'b1;
        if (pc == HIGH_LAST) state_nx = ST_LOW;
      end
      ST_LOW: begin
        if (!i_enable) begin
          state_nx = ST_IDLE;
        end else if (pc == per_last) begin
          if (mode_q == MODE_BURST && burst_cnt == BURST_LAST) begin
            state_nx = ST_GAP;
            pc_nx    = '0;
            gap_nx   = '0;
          end else begin
            start = 1'b1;
          end
        end else begin
          pc_nx = pc + 1'b1;
        end
      end
      ST_GAP: begin
        if (!i_enable)                 state_nx = ST_IDLE;
        else if (gap_cnt == GAP_LAST)  start    = 1'b1;
        else                           gap_nx   = gap_cnt + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    // burst_cnt indexes the pulse within a burst; only back-to-back burst pulses advance it.
    if (start) begin
      state_nx  = ST_HIGH;
      pc_nx     = '0;
      gap_nx    = '0;
      mode_nx   = mode_e'(i_mode);
      bounce_nx = i_bounce_en;
      burst_nx  = (state == ST_LOW && mode_q == MODE_BURST && mode_nx == MODE_BURST) ?
                  burst_cnt + 1'b1 : '0;
    end

    if (state_nx == ST_IDLE) begin
      pc_nx    = '0;
      gap_nx   = '0;
      burst_nx = '0;
    end

    cnt_nx = (i_clr ? 16'd0 : o_pulse_cnt) + {15'd0, start};
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      gap_cnt     <= '0;
      mode_q      <= MODE_32;
      bounce_q    <= 1'b0;
      burst_cnt   <= '0;
      o_pulse_cnt <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      gap_cnt     <= gap_nx;
      mode_q      <= mode_nx;
      bounce_q    <= bounce_nx;
      burst_cnt   <= burst_nx;
      o_pulse_cnt <= cnt_nx;
      o_busy      <= (state_nx != ST_IDLE);
    end
  end

  pulse_bounce_shaper #(
    .PCW        (PCW),
    .HIGH_CYC   (HIGH_CYC),
    .BOUNCE_CYC (BOUNCE_CYC)
  ) u_shaper (
    .clk100Mhz (clk100Mhz),
    .rst_n     (rst_n),
    .state_nx  (state_nx),
    .pc        (pc_nx),
    .bounce_en (bounce_nx),
    .pulse     (o_pulse)
  );

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: timeline model compared every cycle, plus directed literal checks.
module tb_step_pulse_gen;

  localparam int CLK_HZ     = 12800;
  localparam int HIGH_CYC   = 10;
  localparam int BOUNCE_CYC = 4;
  localparam int BURST_LEN  = 16;

  logic        clk100Mhz   = 1'b0;
  logic        rst_n       = 1'b0;
  logic        i_enable    = 1'b0;
  logic [1:0]  i_mode      = 2'd0;
  logic        i_bounce_en = 1'b0;
  logic        i_clr       = 1'b0;
  logic        o_pulse;
  logic [15:0] o_pulse_cnt;
  logic        o_busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit preload_vld = 1'b0;

  step_pulse_gen #(
    .CLK_HZ     (CLK_HZ),
    .HIGH_CYC   (HIGH_CYC),
    .BOUNCE_CYC (BOUNCE_CYC),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk100Mhz   (clk100Mhz),
    .rst_n       (rst_n),
    .i_enable    (i_enable),
    .i_mode      (i_mode),
    .i_bounce_en (i_bounce_en),
    .i_clr       (i_clr),
    .o_pulse     (o_pulse),
    .o_pulse_cnt (o_pulse_cnt),
    .o_busy      (o_busy)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  always @(posedge clk100Mhz) cyc <= cyc + 1;

  // Model: position t within the current pulse period, or g within the inter-burst gap.
  typedef struct {
    bit          busy;
    bit          gap;
    bit          bnc;
    bit          burst;
    int          t;
    int          g;
    int          per;
    int          idx;
    logic [15:0] cnt;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic en, logic [1:0] md, logic bn,
                                         logic clr, bit pre);
    mstate_t n = s;
    bit start = 1'b0;
    bit from_low = 1'b0;
    int rate;
    if (!s.busy) begin
      start = en;
    end else if (s.gap) begin
      if (!en) n.busy = 1'b0;
      else if (s.g == CLK_HZ - 1) start = 1'b1;
      else n.g = s.g + 1;
    end else if (s.t < HIGH_CYC) begin
      n.t = s.t + 1;
    end else if (!en) begin
      n.busy = 1'b0;
    end else if (s.t == s.per - 1) begin
      if (s.burst && s.idx == BURST_LEN) begin
        n.gap = 1'b1;
        n.g   = 0;
      end else begin
        start    = 1'b1;
        from_low = 1'b1;
      end
    end else begin
      n.t = s.t + 1;
    end
    if (clr) n.cnt = 16'd0;
    if (start) begin
      rate   = (md == 2'd0) ? 32 : (md == 2'd1) ? 64 : 128;
      n.cnt  = n.cnt + 16'd1;
      n.idx  = (from_low && s.burst && md == 2'd3) ? s.idx + 1 : 1;
      n.burst = (md == 2'd3);
      n.per  = CLK_HZ / rate;
      n.bnc  = bn;
      n.t    = 0;
      n.gap  = 1'b0;
      n.busy = 1'b1;
    end
    if (pre) n.cnt = 16'hFFFE;
    return n;
  endfunction

  function automatic int exp_pulse(mstate_t s);
    return (s.busy && !s.gap && s.t < HIGH_CYC &&
            !(s.bnc && s.t < BOUNCE_CYC && (s.t % 2) == 1)) ? 1 : 0;
  endfunction

  always @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, i_enable, i_mode, i_bounce_en, i_clr, preload_vld);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk100Mhz);
  endtask

  task automatic wait_start(input string nm, output int c);
    logic [15:0] p;
    int n;
    p = o_pulse_cnt;
    n = 0;
    while (o_pulse_cnt == p && n < 20000) begin
      @(negedge clk100Mhz);
      n++;
    end
    if (o_pulse_cnt == p) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no pulse start within %0d cycles", nm, n);
    end
    c = cyc;
  endtask

  initial begin
    int s1, s2, s3, s4, s5, s6, s7, s, prev, hi;
    logic [10:0] shape;

    fork
      forever begin
        @(negedge clk100Mhz);
        check("o_pulse", int'(o_pulse), exp_pulse(m));
        check("o_busy", int'(o_busy), int'(m.busy));
        check("o_pulse_cnt", int'(o_pulse_cnt), int'(m.cnt));
      end
    join_none

    tick(3);
    rst_n = 1'b1;
    check("rst_pulse", int'(o_pulse), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_cnt", int'(o_pulse_cnt), 0);
    tick(2);

    // 32/s, no bounce
    i_enable = 1'b1; i_mode = 2'd0; i_bounce_en = 1'b0;
    tick(1);
    check("t1_latency", int'(o_pulse), 1);
    check("t1_cnt1", int'(o_pulse_cnt), 1);
    s1 = cyc;
    wait_start("t1_rise2", s2);
    check("t1_space12", s2 - s1, 400);
    wait_start("t1_rise3", s3);
    check("t1_space23", s3 - s2, 400);
    check("t1_cnt3", int'(o_pulse_cnt), 3);
    check("t1_busy", int'(o_busy), 1);
    tick(9);
    check("t1_high_last", int'(o_pulse), 1);
    tick(1);
    check("t1_low_first", int'(o_pulse), 0);

    // 128/s with bounce, then a mid-period switch to 64/s
    i_mode = 2'd2; i_bounce_en = 1'b1;
    wait_start("t2_rise4", s4);
    check("t2_space_old_mode", s4 - s3, 400);
    shape[10] = o_pulse;
    for (int i = 9; i >= 0; i--) begin
      tick(1);
      shape[i] = o_pulse;
    end
    check("t2_bounce_shape", int'(shape), int'(11'b10101111110));
    wait_start("t2_rise5", s5);
    check("t2_space128", s5 - s4, 100);
    tick(50);
    i_mode = 2'd1;
    wait_start("t2_rise6", s6);
    check("t2_space_mid_switch", s6 - s5, 100);
    wait_start("t2_rise7", s7);
    check("t2_space64", s7 - s6, 200);

    // two bursts with the 1 s gap between them
    i_mode = 2'd3; i_bounce_en = 1'b0; i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    check("t3_clr", int'(o_pulse_cnt), 0);
    prev = s7;
    for (int i = 1; i <= 32; i++) begin
      wait_start("t3_rise", s);
      check("t3_space", s - prev, (i == 1) ? 200 : (i == 17) ? 12900 : 100);
      prev = s;
    end
    check("t3_cnt32", int'(o_pulse_cnt), 32);

    // enable dropped inside HIGH
    tick(3);
    i_enable = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      hi += int'(o_pulse);
    end
    check("t4_high_after_drop", hi, 6);
    check("t4_busy_idle", int'(o_busy), 0);
    tick(500);
    check("t4_cnt_hold", int'(o_pulse_cnt), 32);
    i_mode = 2'd0; i_enable = 1'b1;
    tick(1);
    check("t4_reenable_rise", int'(o_pulse), 1);
    check("t4_reenable_cnt", int'(o_pulse_cnt), 33);

    // counter wrap and clear coincident with a start
    i_enable = 1'b0;
    tick(20);
    #1;
    force dut.o_pulse_cnt = 16'hFFFE;
    preload_vld = 1'b1;
    tick(2);
    #1;
    release dut.o_pulse_cnt;
    preload_vld = 1'b0;
    i_mode = 2'd2; i_enable = 1'b1;
    tick(1);
    check("t5_cnt_ffff", int'(o_pulse_cnt), 65535);
    wait_start("t5_wrap_rise", s);
    check("t5_cnt_wrap", int'(o_pulse_cnt), 0);
    tick(99);
    i_clr = 1'b1;
    tick(1);
    check("t5_clr_with_start", int'(o_pulse_cnt), 1);
    check("t5_clr_pulse", int'(o_pulse), 1);
    i_clr = 1'b0;

    // asynchronous reset in the middle of HIGH
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_pulse", int'(o_pulse), 0);
    check("t6_async_busy", int'(o_busy), 0);
    check("t6_async_cnt", int'(o_pulse_cnt), 0);
    i_enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t6_no_pulse", int'(o_pulse), 0);
    i_mode = 2'd0; i_enable = 1'b1;
    tick(1);
    check("t6_rise", int'(o_pulse), 1);
    check("t6_cnt", int'(o_pulse_cnt), 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Programmable step-pulse source that drives a step-like signal into the tracker's input-conditioning path (the debouncer), for demo mode and self-test.
- Emits a periodic single-bit pulse train at one of three fixed rates, or a burst profile.
- Optionally emulates mechanical contact bounce on each rising edge, so downstream debouncing is exercised on silicon.
- Sits beside the debouncer; its o_pulse is muxed onto the sensor input under a demo-mode select.

Parameters:
CLK_HZ, 100000000, clock frequency in Hz; period for rate R = CLK_HZ/R cycles (integer divide).
HIGH_CYC, 1000, cycles o_pulse is nominally high per pulse; must be < CLK_HZ/128.
BOUNCE_CYC, 8, length of the bounce window at pulse start; must be < HIGH_CYC.
BURST_LEN, 16, pulses per burst in burst mode.

Ports:
clk100Mhz  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
i_enable  in  1  level; 1 = generate pulses
i_mode  in  2  00 = 32/s, 01 = 64/s, 10 = 128/s, 11 = burst
i_bounce_en  in  1  1 = add bounce chatter at each rising edge
i_clr  in  1  synchronous clear of o_pulse_cnt
o_pulse  out  1  generated pulse train (registered)
o_pulse_cnt  out  16  number of pulses started
o_busy  out  1  1 whenever the FSM is not IDLE

Behaviour:
- Reset (rst_n = 0, async): FSM = IDLE, o_pulse = 0, o_pulse_cnt = 0, o_busy = 0, all counters = 0.
- FSM states: IDLE, HIGH, LOW, GAP. All outputs are registered and update on the same edge as the state.
- IDLE -> HIGH on the first edge where i_enable = 1.
  - At that edge: period counter pc = 0, i_mode latched, o_pulse = 1, o_pulse_cnt += 1.
  - Latency from i_enable sampled to o_pulse high is 1 edge.
- Period counter pc increments every cycle from 0 to P-1.
  - P = CLK_HZ/32, CLK_HZ/64 or CLK_HZ/128 per the latched mode. Burst mode uses the 128/s period.
- HIGH: o_pulse = 1 while pc < HIGH_CYC.
  - If i_bounce_en was latched 1 at pulse start, o_pulse = ~pc[0] for pc < BOUNCE_CYC (chatter), then steady 1.
- HIGH -> LOW when pc = HIGH_CYC. o_pulse = 0 in LOW.
- LOW, pc = P-1, next edge:
  - If i_enable = 1 and no gap is due: start the next pulse (pc = 0, HIGH, re-latch i_mode and i_bounce_en, count += 1). Rise-to-rise spacing is exactly P cycles.
  - If i_enable = 0: go to IDLE.
- i_enable deasserted during HIGH: the pulse completes its full HIGH_CYC (no truncated pulse). The FSM goes to IDLE on the first LOW cycle where i_enable = 0.
- i_enable deasserted during LOW: go to IDLE on the next edge.
- In IDLE, o_pulse is always 0.
- Mode changes mid-period are ignored until the next pulse start.
- Burst mode: a 4-bit burst counter counts pulse starts.
  - After the BURST_LEN-th pulse's LOW phase ends, enter GAP: o_pulse = 0 for CLK_HZ cycles (1 s), then start a new burst.
  - i_enable = 0 in GAP goes to IDLE on the next edge. The burst counter clears on leaving burst mode or on entering IDLE.
- o_pulse_cnt wraps 0xFFFF -> 0x0000.
  - i_clr = 1 forces it to 0.
  - i_clr coincident with a pulse start gives 1 (clear takes effect first, then the increment).
- Width rules: pc and the gap counter are sized $clog2(CLK_HZ)+1 bits. All comparisons are unsigned.
- Reset asserted mid-pulse: o_pulse drops to 0 immediately (async). Generation resumes only on a fresh i_enable sample after release.

Decomposition:
- Package step_gen_pkg holds: mode encodings (MODE_32, MODE_64, MODE_128, MODE_BURST), the FSM state enum, and rate constants 32/64/128.
- One sub-module, pulse_bounce_shaper. It is purely combinational-plus-register: given pc, HIGH_CYC, BOUNCE_CYC and the latched bounce enable, it produces the registered o_pulse.
- The FSM, counters and mode latch stay in the top level.

Test Plan (CLK_HZ=12800, HIGH_CYC=10, BOUNCE_CYC=4, BURST_LEN=16; periods 400/200/100):
1. Reset, then i_enable=1, i_mode=00, i_bounce_en=0 -> o_pulse high 1 edge later for exactly 10 cycles; rises 400 cycles apart; o_pulse_cnt=3 after the third rise; o_busy=1.
2. i_mode=10, i_bounce_en=1 -> each pulse reads 1,0,1,0 then 1 for 6 cycles; spacing 100; switching to mode 01 mid-period takes effect at the next rise (spacing 200).
3. i_mode=11 -> 16 pulses at 100-cycle spacing, o_pulse low for 100+12800 cycles after the 16th rise, then the next burst; o_pulse_cnt=32 after two bursts.
4. i_enable dropped at pc=3 of a pulse -> pulse still 10 cycles wide, then IDLE, o_busy=0, no further rises; re-enable -> rise 1 edge later.
5. o_pulse_cnt preloaded near wrap (run to 0xFFFF) -> next pulse gives 0x0000; i_clr coincident with a pulse start -> 1.
6. rst_n pulsed low mid-HIGH -> o_pulse, o_busy and o_pulse_cnt go to 0 asynchronously; no pulse until i_enable is sampled after release.
